store_buffer: RTL and testbench

- Posted-write buffer between the MEM pipeline stage and the byte-addressed data memory. The memory stores big-endian words: byte address A holds bits 31:24.
- Accepts word stores from the pipeline in one cycle and drains them to memory when the shared memory address port is idle.
- Services loads with youngest-match store-to-load forwarding, so buffered stores stay architecturally visible.
- Sits directly upstream of the data memory and owns its address, write and read-enable inputs.

---
 rtl/store_buffer.sv | 110 +++++++++++
 tb/tb_store_buffer.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/store_buffer.sv
// Posted-write store buffer in front of the data memory: queues word stores,
// drains them when the memory port is idle and forwards buffered data to loads.
module store_buffer #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       st_valid,
  input  logic [ADDR_W-1:0]          st_addr,
  input  logic [DATA_W-1:0]          st_data,
  output logic                       st_ready,
  input  logic                       ld_en,
  input  logic [ADDR_W-1:0]          ld_addr,
  output logic [DATA_W-1:0]          ld_data,
  output logic                       ld_hit,
  output logic [ADDR_W-1:0]          mem_address,
  output logic [DATA_W-1:0]          mem_write_bus,
  output logic                       mem_write_en,
  output logic                       mem_read_en,
  input  logic [DATA_W-1:0]          mem_out_bus,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [ADDR_W-1:0] addr_q [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [PTR_W-1:0]  head_q, head_d;
  logic [PTR_W-1:0]  tail_q, tail_d;
  logic [CNT_W-1:0]  count_q, count_d;

  logic              accept;
  logic              drain;
  logic              fwd_hit;
  logic [DATA_W-1:0] fwd_data;
  logic [PTR_W-1:0]  idx;

  assign st_ready = (count_q != CNT_W'(DEPTH));
  assign accept   = st_valid && st_ready;
  assign drain    = !ld_en && (count_q != '0);
  assign count    = count_q;

  always_comb begin
    mem_address   = '0;
    mem_write_bus = '0;
    mem_write_en  = 1'b0;
    mem_read_en   = 1'b0;
    if (ld_en) begin
      mem_address = ld_addr;
      mem_read_en = 1'b1;
    end else if (drain) begin
      mem_address   = addr_q[head_q];
      mem_write_bus = data_q[head_q];
      mem_write_en  = 1'b1;
    end
  end

  // Walk oldest to youngest so the last match (nearest tail) wins.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    idx      = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head_q + PTR_W'(i);
      if ((CNT_W'(i) < count_q) &&
          (addr_q[idx][ADDR_W-1:2] == ld_addr[ADDR_W-1:2])) begin
        fwd_hit  = 1'b1;
        fwd_data = data_q[idx];
      end
    end
  end

  assign ld_hit  = ld_en && fwd_hit;
  assign ld_data = ld_hit ? fwd_data : mem_out_bus;

  always_comb begin
    head_d  = drain  ? head_q + PTR_W'(1) : head_q;
    tail_d  = accept ? tail_q + PTR_W'(1) : tail_q;
    count_d = count_q;
    case ({accept, drain})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Entry payload needs no reset; validity is carried by count and head.
  always_ff @(posedge clk) begin
    if (accept) begin
      addr_q[tail_q] <= st_addr;
      data_q[tail_q] <= st_data;
    end
  end

endmodule

// File: tb/tb_store_buffer.sv
// Directed bench for store_buffer: a scoreboard queue holds the expected memory
// writes in drain order; a negedge monitor pops and compares each strobe.
module tb_store_buffer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        st_valid;
  logic [31:0] st_addr;
  logic [31:0] st_data;
  logic        st_ready;
  logic        ld_en;
  logic [31:0] ld_addr;
  logic [31:0] ld_data;
  logic        ld_hit;
  logic [31:0] mem_address;
  logic [31:0] mem_write_bus;
  logic        mem_write_en;
  logic        mem_read_en;
  logic [31:0] mem_out_bus;
  logic [2:0]  count;

  logic        bd_we;
  logic [7:0]  bd_addr;
  logic [31:0] bd_data;
  logic [31:0] mem [0:255] = '{default: 32'h0};

  int n_cmp = 0;
  int n_err = 0;
  logic [63:0] exp_q [$];

  always #5 clk = ~clk;

  store_buffer #(.DEPTH(4), .ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .st_valid(st_valid), .st_addr(st_addr), .st_data(st_data), .st_ready(st_ready),
    .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data), .ld_hit(ld_hit),
    .mem_address(mem_address), .mem_write_bus(mem_write_bus),
    .mem_write_en(mem_write_en), .mem_read_en(mem_read_en),
    .mem_out_bus(mem_out_bus), .count(count)
  );

  // Word-addressed memory model, 256 words
  assign mem_out_bus = mem[mem_address[9:2]];
  always @(posedge clk) begin
    if (bd_we) mem[bd_addr] <= bd_data;
    else if (mem_write_en) mem[mem_address[9:2]] <= mem_write_bus;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor: every memory write strobe must match the queue head
  always @(negedge clk) begin
    if (mem_write_en) begin
      logic [63:0] e;
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_write: got addr %h data %h expected none", mem_address, mem_write_bus);
      end else begin
        e = exp_q.pop_front();
        if (mem_address !== e[63:32] || mem_write_bus !== e[31:0]) begin
          n_err++;
          $display("FAIL drain_order: got addr %h data %h expected addr %h data %h",
                   mem_address, mem_write_bus, e[63:32], e[31:0]);
        end
      end
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic sv, input logic [31:0] sa, input logic [31:0] sd,
                       input logic le, input logic [31:0] la);
    st_valid = sv; st_addr = sa; st_data = sd; ld_en = le; ld_addr = la;
  endtask

  initial begin
    rst_n = 1'b0;
    drive(1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
    bd_we = 1'b1; bd_addr = 8'h09; bd_data = 32'h0BADF00D;
    #2;
    chk("rst_st_ready", {31'b0, st_ready}, 32'd1);
    chk("rst_count", {29'b0, count}, 32'd0);
    chk("rst_wen", {31'b0, mem_write_en}, 32'd0);
    chk("rst_ren", {31'b0, mem_read_en}, 32'd0);
    chk("rst_hit", {31'b0, ld_hit}, 32'd0);
    chk("rst_addr", mem_address, 32'h0);
    chk("rst_wbus", mem_write_bus, 32'h0);
    #5 bd_addr = 8'h40; bd_data = 32'h12345678;
    #10 bd_we = 1'b0;
    #5 rst_n = 1'b1;
    next_cycle();

    // Idle after reset
    @(negedge clk);
    chk("idle_ready", {31'b0, st_ready}, 32'd1);
    chk("idle_wen", {31'b0, mem_write_en}, 32'd0);
    next_cycle();

    // Single store drains on the next cycle
    drive(1'b1, 32'h10, 32'hDEADBEEF, 1'b0, 32'h0);
    exp_q.push_back({32'h10, 32'hDEADBEEF});
    next_cycle();
    drive(1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
    @(negedge clk);
    chk("single_count1", {29'b0, count}, 32'd1);
    chk("single_wen", {31'b0, mem_write_en}, 32'd1);
    chk("single_addr", mem_address, 32'h10);
    chk("single_wbus", mem_write_bus, 32'hDEADBEEF);
    next_cycle();
    chk("single_count0", {29'b0, count}, 32'd0);
    drive(1'b0, 32'h0, 32'h0, 1'b1, 32'h10);
    @(negedge clk);
    chk("readback_hit", {31'b0, ld_hit}, 32'd0);
    chk("readback_data", ld_data, 32'hDEADBEEF);
    next_cycle();

    // Load blocks draining; fill to DEPTH, fifth store is ignored
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 32'h80 + 32'(4 * i), 32'hA0 + 32'(i), 1'b1, 32'h100);
      if (i < 4) exp_q.push_back({32'h80 + 32'(4 * i), 32'hA0 + 32'(i)});
      @(negedge clk);
      chk("fill_ready", {31'b0, st_ready}, (i < 4) ? 32'd1 : 32'd0);
      chk("fill_wen", {31'b0, mem_write_en}, 32'd0);
      chk("fill_ren", {31'b0, mem_read_en}, 32'd1);
      chk("fill_ld_miss", ld_data, 32'h12345678);
      next_cycle();
    end
    chk("fill_count", {29'b0, count}, 32'd4);
    drive(1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("drain_count", {29'b0, count}, 32'(4 - i));
      chk("drain_wen", {31'b0, mem_write_en}, 32'd1);
      next_cycle();
    end
    chk("drained_count", {29'b0, count}, 32'd0);

    // Youngest-match forwarding
    drive(1'b1, 32'h20, 32'h11111111, 1'b1, 32'h20);
    exp_q.push_back({32'h20, 32'h11111111});
    @(negedge clk);
    chk("fwd_same_cycle_hit", {31'b0, ld_hit}, 32'd0);
    next_cycle();
    drive(1'b1, 32'h20, 32'h22222222, 1'b1, 32'h20);
    exp_q.push_back({32'h20, 32'h22222222});
    @(negedge clk);
    chk("fwd_first_hit", {31'b0, ld_hit}, 32'd1);
    chk("fwd_first_data", ld_data, 32'h11111111);
    next_cycle();
    drive(1'b0, 32'h0, 32'h0, 1'b1, 32'h20);
    @(negedge clk);
    chk("fwd_young_hit", {31'b0, ld_hit}, 32'd1);
    chk("fwd_young_data", ld_data, 32'h22222222);
    next_cycle();
    drive(1'b0, 32'h0, 32'h0, 1'b1, 32'h24);
    @(negedge clk);
    chk("miss_hit", {31'b0, ld_hit}, 32'd0);
    chk("miss_data", ld_data, 32'h0BADF00D);
    next_cycle();

    // Simultaneous accept and drain keeps count
    drive(1'b1, 32'h28, 32'h77777777, 1'b0, 32'h0);
    exp_q.push_back({32'h28, 32'h77777777});
    next_cycle();
    chk("acc_drain_count", {29'b0, count}, 32'd2);

    // Refill to full (tail wraps), then one-cycle load gap while storing
    drive(1'b1, 32'h30, 32'h33333333, 1'b1, 32'h30);
    exp_q.push_back({32'h30, 32'h33333333});
    next_cycle();
    drive(1'b1, 32'h34, 32'h44444444, 1'b1, 32'h30);
    exp_q.push_back({32'h34, 32'h44444444});
    next_cycle();
    chk("full_count", {29'b0, count}, 32'd4);
    drive(1'b1, 32'h38, 32'h55555555, 1'b0, 32'h0);
    @(negedge clk);
    chk("gap_ready", {31'b0, st_ready}, 32'd0);
    chk("gap_wen", {31'b0, mem_write_en}, 32'd1);
    next_cycle();
    chk("gap_count", {29'b0, count}, 32'd3);
    drive(1'b1, 32'h38, 32'h55555555, 1'b1, 32'h30);
    exp_q.push_back({32'h38, 32'h55555555});
    @(negedge clk);
    chk("gap_accept_ready", {31'b0, st_ready}, 32'd1);
    chk("gap_fwd_data", ld_data, 32'h33333333);
    next_cycle();
    chk("refull_count", {29'b0, count}, 32'd4);
    drive(1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
    repeat (4) next_cycle();
    chk("final_count", {29'b0, count}, 32'd0);
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    // Reset asserted during a drain cycle drops the pending writes
    drive(1'b1, 32'h40, 32'hAAAAAAAA, 1'b1, 32'h0);
    next_cycle();
    drive(1'b1, 32'h44, 32'hBBBBBBBB, 1'b1, 32'h0);
    next_cycle();
    drive(1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
    #1 rst_n = 1'b0;
    #1;
    chk("midrst_count", {29'b0, count}, 32'd0);
    chk("midrst_wen", {31'b0, mem_write_en}, 32'd0);
    repeat (2) next_cycle();
    rst_n = 1'b1;
    repeat (3) next_cycle();
    chk("midrst_mem_untouched", mem[8'h10], 32'h0);
    chk("midrst_mem_untouched2", mem[8'h11], 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
